serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 16 +
 rtl/subtractor_1_bit.sv | 14 +
 rtl/serial_subtractor.sv | 127 ++++++++++++
 tb/tb_serial_subtractor.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// flag bit positions used when SERIAL_SUB_FLAGS_EN is defined.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/subtractor_1_bit.sv
// One-bit full subtractor cell; the serial datapath reuses it once per cycle.
module subtractor_1_bit (
    input  logic x_current,
    input  logic y_current,
    input  logic borrow_previous,
    output logic diff_current,
    output logic next_borrow
);

    assign diff_current = x_current ^ y_current ^ borrow_previous;
    assign next_borrow  = (~x_current & y_current) |
                          (~(x_current ^ y_current) & borrow_previous);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock, valid/ready on both sides.
// Define SERIAL_SUB_FLAGS_EN to add the registered N,Z,C,V flags output.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    output logic [3:0]       flags
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bin_q, bin_d;
    logic             bit_diff;
    logic             bit_bout;
`ifdef SERIAL_SUB_FLAGS_EN
    logic [3:0]       flags_q, flags_d;
`endif

    // Operands stay latched whole so the flag logic can still see their MSBs.
    subtractor_1_bit u_cell (
        .x_current       (a_q[cnt_q]),
        .y_current       (b_q[cnt_q]),
        .borrow_previous (bin_q),
        .diff_current    (bit_diff),
        .next_borrow     (bit_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            bin_q   <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
            flags_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
`ifdef SERIAL_SUB_FLAGS_EN
            flags_q <= flags_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
`ifdef SERIAL_SUB_FLAGS_EN
        flags_d = flags_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                diff_d = {bit_diff, diff_q[WIDTH-1:1]};
                bin_d  = bit_bout;
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = DONE;
`ifdef SERIAL_SUB_FLAGS_EN
                    // Flags are captured together with the final bit so they hold through DONE.
                    flags_d[FLAG_N] = diff_d[WIDTH-1];
                    flags_d[FLAG_Z] = (diff_d == '0);
                    flags_d[FLAG_C] = ~bit_bout;
                    flags_d[FLAG_V] = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                      (diff_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign borrow    = bin_q;
`ifdef SERIAL_SUB_FLAGS_EN
    assign flags     = flags_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=8 using an expected-result queue.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUB_FLAGS_EN
    logic [3:0]   flags;
`endif

    typedef struct {
        logic [W-1:0] d;
        logic         br;
        logic [3:0]   f;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   lastAccept = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
`ifdef SERIAL_SUB_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        e.d  = av - bv;
        e.br = (av < bv);
        e.f  = {e.d[W-1], (e.d == '0), ~e.br,
                (av[W-1] != bv[W-1]) && (e.d[W-1] != av[W-1])};
        return e;
    endfunction

    // Present one operand pair, record the expected result and scramble inputs after acceptance.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic holdValid);
        int n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        check("in_ready_before_accept", in_ready, 1);
        a = av;
        b = bv;
        in_valid = 1'b1;
        sb.push_back(model(av, bv));
        tick();
        lastAccept = cycle;
        in_valid = holdValid;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    // Wait for the result, confirm the latency and compare against the queue head.
    task automatic checkOutput();
        int n = 0;
        exp_t e;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check("latency_edges", n, W);
        check("in_ready_in_done", in_ready, 0);
        check("scoreboard_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("diff", diff, e.d);
            check("borrow", borrow, e.br);
`ifdef SERIAL_SUB_FLAGS_EN
            check("flags", flags, e.f);
`endif
        end
    endtask

    task automatic releaseOutput(input logic keepReady);
        out_ready = 1'b1;
        tick();
        check("out_valid_after_release", out_valid, 0);
        check("in_ready_after_release", in_ready, 1);
        out_ready = keepReady;
    endtask

    initial begin
        logic [W-1:0] heldDiff;
        logic         heldBorrow;
        int           prevAccept;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_diff", diff, 0);
        check("reset_borrow", borrow, 0);
`ifdef SERIAL_SUB_FLAGS_EN
        check("reset_flags", flags, 0);
`endif
        #1 rst_n = 1'b1;
        tick();

        $display("[TB] directed vectors");
        applyStimulus(8'h05, 8'h03, 1'b0); checkOutput(); releaseOutput(1'b0);
        applyStimulus(8'h00, 8'h01, 1'b0); checkOutput(); releaseOutput(1'b0);
        applyStimulus(8'h80, 8'h01, 1'b0); checkOutput(); releaseOutput(1'b0);
        applyStimulus(8'h10, 8'h10, 1'b0); checkOutput(); releaseOutput(1'b0);
        applyStimulus(8'h7F, 8'hFF, 1'b0); checkOutput(); releaseOutput(1'b0);

        $display("[TB] back-pressure");
        applyStimulus(8'hC3, 8'h5A, 1'b0);
        checkOutput();
        heldDiff   = diff;
        heldBorrow = borrow;
        for (int i = 0; i < 5; i++) begin
            a        = W'($urandom);
            b        = W'($urandom);
            in_valid = i[0];
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_diff_stable", diff, heldDiff);
            check("bp_borrow_stable", borrow, heldBorrow);
        end
        in_valid = 1'b0;
        releaseOutput(1'b0);
        tick();
        check("bp_no_second_accept", in_ready, 1);

        $display("[TB] reset mid-shift");
        applyStimulus(8'h33, 8'h11, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_diff", diff, 0);
        sb.delete();
        #3 rst_n = 1'b1;
        tick();
        applyStimulus(8'h20, 8'h01, 1'b0); checkOutput(); releaseOutput(1'b0);

        $display("[TB] back-to-back random");
        out_ready  = 1'b1;
        prevAccept = 0;
        for (int k = 0; k < 100; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            applyStimulus(ra, rb, 1'b1);
            if (k > 0) check("issue_interval", lastAccept - prevAccept, W + 2);
            prevAccept = lastAccept;
            checkOutput();
            releaseOutput(1'b1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
